// File: rtl/skin_centroid_tracker.sv
// Skin-colour classifier and per-frame hand centroid for the OV7670 RGB565 stream.
// Accumulates skin pixel statistics per frame and divides them sequentially at end of frame.
module skin_centroid_tracker #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int CNT_W      = 19,
    parameter int SUM_W      = 28,
    parameter int R_MIN      = 12,
    parameter int G_MARGIN   = 8,
    parameter int B_MARGIN   = 4,
    parameter int MIN_PIXELS = 256
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [15:0]      pixel_data,
    input  logic             pixel_valid,
    input  logic             frame_done,
    output logic [9:0]       centroid_x,
    output logic [9:0]       centroid_y,
    output logic [CNT_W-1:0] skin_count,
    output logic             hand_present,
    output logic             result_valid,
    output logic             overrun
);

    localparam int BIT_W = $clog2(SUM_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DIV_X = 3'd2,
        ST_DIV_Y = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
        if (a == {CNT_W{1'b1}}) begin
            return a;
        end else begin
            return a + CNT_W'(1'b1);
        end
    endfunction

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [9:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {{(SUM_W-9){1'b0}}, b};
        if (s[SUM_W]) begin
            return {SUM_W{1'b1}};
        end else begin
            return s[SUM_W-1:0];
        end
    endfunction

    state_t           state_r, state_nxt_s;
    logic [4:0]       r5_s, b5_s;
    logic [5:0]       g6_s;
    logic             skin_s, hit_s;
    logic [9:0]       x_r, y_r;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, snap_cnt_r;
    logic [SUM_W-1:0] sumx_r, sumy_r, sumx_nxt_s, sumy_nxt_s;
    logic [SUM_W-1:0] snap_sumy_r, snap_sumx_r, dvd_r;
    logic [CNT_W-1:0] rem_r, rem_nxt_s;
    logic [CNT_W:0]   rem_sh_s;
    logic             qbit_s, last_bit_s;
    logic [BIT_W-1:0] bit_r;
    logic [9:0]       qx_r, qy_r;

    // Fixed-threshold skin classifier; all sums are 7 bits so none overflow.
    always_comb begin
        r5_s   = pixel_data[15:11];
        g6_s   = pixel_data[10:5];
        b5_s   = pixel_data[4:0];
        skin_s = ({2'b00, r5_s} >= 7'(R_MIN)) &&
                 ({1'b0, r5_s, 1'b0} > ({1'b0, g6_s} + 7'(G_MARGIN))) &&
                 ({2'b00, r5_s} > ({2'b00, b5_s} + 7'(B_MARGIN)));
        hit_s  = pixel_valid && skin_s;
    end

    // Accumulator values including the current pixel, shared by update and snapshot.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        sumx_nxt_s = sumx_r;
        sumy_nxt_s = sumy_r;
        if (hit_s) begin
            cnt_nxt_s  = sat_inc(cnt_r);
            sumx_nxt_s = sat_add(sumx_r, x_r);
            sumy_nxt_s = sat_add(sumy_r, y_r);
        end else begin
            cnt_nxt_s  = cnt_r;
        end
    end

    // Pixel coordinates and per-frame accumulators; frame_done always starts a fresh frame.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= 10'd0;
            y_r    <= 10'd0;
            cnt_r  <= {CNT_W{1'b0}};
            sumx_r <= {SUM_W{1'b0}};
            sumy_r <= {SUM_W{1'b0}};
        end else if (frame_done) begin
            x_r    <= 10'd0;
            y_r    <= 10'd0;
            cnt_r  <= {CNT_W{1'b0}};
            sumx_r <= {SUM_W{1'b0}};
            sumy_r <= {SUM_W{1'b0}};
        end else begin
            cnt_r  <= cnt_nxt_s;
            sumx_r <= sumx_nxt_s;
            sumy_r <= sumy_nxt_s;
            if (pixel_valid) begin
                if (x_r == 10'(IMG_W - 1)) begin
                    x_r <= 10'd0;
                    if (y_r != 10'(IMG_H - 1)) begin
                        y_r <= y_r + 10'd1;
                    end
                end else begin
                    x_r <= x_r + 10'd1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: one LOAD cycle, SUM_W steps per coordinate, one DONE cycle.
    always_comb begin
        state_nxt_s = state_r;
        last_bit_s  = (bit_r == BIT_W'(SUM_W - 1));
        case (state_r)
            ST_IDLE:  state_nxt_s = frame_done ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_nxt_s = ST_DIV_X;
            ST_DIV_X: state_nxt_s = last_bit_s ? ST_DIV_Y : ST_DIV_X;
            ST_DIV_Y: state_nxt_s = last_bit_s ? ST_DONE : ST_DIV_Y;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh_s = {rem_r, dvd_r[SUM_W-1]};
        if (rem_sh_s >= {1'b0, snap_cnt_r}) begin
            qbit_s    = 1'b1;
            rem_nxt_s = CNT_W'(rem_sh_s - {1'b0, snap_cnt_r});
        end else begin
            qbit_s    = 1'b0;
            rem_nxt_s = rem_sh_s[CNT_W-1:0];
        end
    end

    // Snapshot and shared divider datapath; quotients shift straight into qx_r/qy_r.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_cnt_r  <= {CNT_W{1'b0}};
            snap_sumx_r <= {SUM_W{1'b0}};
            snap_sumy_r <= {SUM_W{1'b0}};
            dvd_r       <= {SUM_W{1'b0}};
            rem_r       <= {CNT_W{1'b0}};
            bit_r       <= {BIT_W{1'b0}};
            qx_r        <= 10'd0;
            qy_r        <= 10'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_done) begin
                        snap_cnt_r  <= cnt_nxt_s;
                        snap_sumx_r <= sumx_nxt_s;
                        snap_sumy_r <= sumy_nxt_s;
                    end
                end
                ST_LOAD: begin
                    dvd_r <= snap_sumx_r;
                    rem_r <= {CNT_W{1'b0}};
                    bit_r <= {BIT_W{1'b0}};
                end
                ST_DIV_X, ST_DIV_Y: begin
                    if (state_r == ST_DIV_X) begin
                        qx_r <= {qx_r[8:0], qbit_s};
                    end else begin
                        qy_r <= {qy_r[8:0], qbit_s};
                    end
                    if (last_bit_s) begin
                        dvd_r <= snap_sumy_r;
                        rem_r <= {CNT_W{1'b0}};
                        bit_r <= {BIT_W{1'b0}};
                    end else begin
                        dvd_r <= {dvd_r[SUM_W-2:0], 1'b0};
                        rem_r <= rem_nxt_s;
                        bit_r <= bit_r + BIT_W'(1'b1);
                    end
                end
                ST_DONE: begin
                    bit_r <= {BIT_W{1'b0}};
                end
                default: begin
                    bit_r <= {BIT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered outputs; an empty frame bypasses the meaningless quotient.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            centroid_x   <= 10'd0;
            centroid_y   <= 10'd0;
            skin_count   <= {CNT_W{1'b0}};
            hand_present <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun      <= frame_done && (state_r != ST_IDLE);
            result_valid <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                skin_count   <= snap_cnt_r;
                hand_present <= (snap_cnt_r >= CNT_W'(MIN_PIXELS));
                if (snap_cnt_r == {CNT_W{1'b0}}) begin
                    centroid_x <= 10'd0;
                    centroid_y <= 10'd0;
                end else begin
                    centroid_x <= qx_r;
                    centroid_y <= qy_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_skin_centroid_tracker.sv
// Directed bench for skin_centroid_tracker on a small 8x4 image.
module tb_skin_centroid_tracker;

    localparam int CNT_W = 19;
    localparam int SUM_W = 28;
    localparam int LAT   = 2 * SUM_W + 2;

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic [15:0]      pixel_data;
    logic             pixel_valid;
    logic             frame_done;
    logic [9:0]       centroid_x;
    logic [9:0]       centroid_y;
    logic [CNT_W-1:0] skin_count;
    logic             hand_present;
    logic             result_valid;
    logic             overrun;

    int errors = 0;
    int checks = 0;

    skin_centroid_tracker #(
        .IMG_W(8), .IMG_H(4), .CNT_W(CNT_W), .SUM_W(SUM_W),
        .R_MIN(12), .G_MARGIN(8), .B_MARGIN(4), .MIN_PIXELS(1)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .centroid_x  (centroid_x),
        .centroid_y  (centroid_y),
        .skin_count  (skin_count),
        .hand_present(hand_present),
        .result_valid(result_valid),
        .overrun     (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at a negedge and return at the following negedge.
    task automatic step(input logic pv, input logic [15:0] d, input logic fd);
        pixel_valid = pv;
        pixel_data  = d;
        frame_done  = fd;
        @(negedge sys_clk);
        pixel_valid = 1'b0;
        pixel_data  = 16'h0000;
        frame_done  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int s0, input int s1, input int s2);
        for (int i = 0; i < n; i++) begin
            step(1'b1, (i == s0 || i == s1 || i == s2) ? 16'hF800 : 16'h0000, 1'b0);
        end
    endtask

    // Close the frame (optionally with a coincident pixel) and check the delivered result.
    task automatic expect_result(input string tag, input logic fd_pv, input logic [15:0] fd_d,
                                 input int cnt, input int cx, input int cy, input int hp);
        int lat;
        lat = 0;
        step(fd_pv, fd_d, 1'b1);
        for (int k = 1; k <= LAT + 20; k++) begin
            step(1'b0, 16'h0000, 1'b0);
            if (result_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".latency"}, lat, LAT);
        chk({tag, ".skin_count"}, skin_count, cnt);
        chk({tag, ".centroid_x"}, centroid_x, cx);
        chk({tag, ".centroid_y"}, centroid_y, cy);
        chk({tag, ".hand_present"}, hand_present, hp);
        step(1'b0, 16'h0000, 1'b0);
        chk({tag, ".rv_pulse"}, result_valid, 0);
        chk({tag, ".hold"}, skin_count, cnt);
    endtask

    initial begin
        int ovc, ovk, rvk, rvn;
        rst_n       = 1'b0;
        pixel_data  = 16'h0000;
        pixel_valid = 1'b0;
        frame_done  = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset.centroid_x", centroid_x, 0);
        chk("reset.centroid_y", centroid_y, 0);
        chk("reset.skin_count", skin_count, 0);
        chk("reset.hand_present", hand_present, 0);
        chk("reset.result_valid", result_valid, 0);
        chk("reset.overrun", overrun, 0);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // Classifier via single-pixel frames.
        step(1'b1, 16'hF800, 1'b0);
        expect_result("cls_F800", 1'b0, 16'h0000, 1, 0, 0, 1);
        step(1'b1, 16'hFFFF, 1'b0);
        expect_result("cls_FFFF", 1'b0, 16'h0000, 0, 0, 0, 0);
        step(1'b1, 16'hF800, 1'b0);
        expect_result("cls_F800b", 1'b0, 16'h0000, 1, 0, 0, 1);
        step(1'b1, 16'h0000, 1'b0);
        expect_result("cls_0000", 1'b0, 16'h0000, 0, 0, 0, 0);
        step(1'b1, 16'h07E0, 1'b0);
        expect_result("cls_07E0", 1'b0, 16'h0000, 0, 0, 0, 0);

        // (2,1),(4,1),(3,3): sums 9/5 over 3.
        send_frame(32, 10, 12, 27);
        expect_result("cent_a", 1'b0, 16'h0000, 3, 3, 1, 1);
        // (7,2),(6,3),(5,3): sums 18/8 over 3, floor division.
        send_frame(32, 23, 30, 29);
        expect_result("cent_b", 1'b0, 16'h0000, 3, 6, 2, 1);
        // Fifth line stays at row 3: (0,0),(7,3) -> 7/2, 3/2.
        send_frame(40, 0, 39, -1);
        expect_result("ysat", 1'b0, 16'h0000, 2, 3, 1, 1);
        send_frame(32, -1, -1, -1);
        expect_result("empty", 1'b0, 16'h0000, 0, 0, 0, 0);

        // Overrun: second frame_done 10 cycles after the first.
        send_frame(32, 10, 12, 27);
        step(1'b0, 16'h0000, 1'b1);
        ovc = 0; ovk = 0; rvk = 0; rvn = 0;
        for (int k = 1; k <= LAT + 20; k++) begin
            step(k <= 2, 16'hF800, k == 10);
            if (overrun === 1'b1) begin
                ovc++;
                ovk = k;
            end
            if (result_valid === 1'b1) begin
                rvn++;
                if (rvk == 0) begin
                    rvk = k;
                    chk("ovr.skin_count", skin_count, 3);
                    chk("ovr.centroid_x", centroid_x, 3);
                    chk("ovr.centroid_y", centroid_y, 1);
                end
            end
        end
        chk("ovr.pulses", ovc, 1);
        chk("ovr.when", ovk, 10);
        chk("ovr.latency", rvk, LAT);
        chk("ovr.rv_count", rvn, 1);
        send_frame(3, 2, -1, -1);
        expect_result("after_ovr", 1'b0, 16'h0000, 1, 2, 0, 1);

        // Pixel coincident with frame_done belongs to the closing frame.
        send_frame(5, 1, -1, -1);
        expect_result("b2b_close", 1'b1, 16'hF800, 2, 3, 0, 1);
        send_frame(2, 1, -1, -1);
        expect_result("b2b_next", 1'b0, 16'h0000, 1, 1, 0, 1);

        // Asynchronous reset in the middle of DIV_X.
        send_frame(32, 10, 12, 27);
        step(1'b0, 16'h0000, 1'b1);
        repeat (10) step(1'b0, 16'h0000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst.centroid_x", centroid_x, 0);
        chk("arst.skin_count", skin_count, 0);
        chk("arst.hand_present", hand_present, 0);
        chk("arst.result_valid", result_valid, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        rvn = 0;
        for (int k = 0; k < LAT + 20; k++) begin
            step(1'b0, 16'h0000, 1'b0);
            if (result_valid === 1'b1) rvn++;
        end
        chk("arst.no_result", rvn, 0);
        send_frame(4, 3, -1, -1);
        expect_result("arst_recover", 1'b0, 16'h0000, 1, 3, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
